// File: rtl/periph_int_gateway.sv
// Level-sensitive interrupt gateway with priority arbitration and claim/complete ownership.
// Each source walks IDLE -> PENDING -> ACTIVE -> IDLE; the arbiter picks the best enabled pending source.
module periph_int_gateway #(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned PRIO_W = 3,
  parameter int unsigned ID_W   = $clog2(N_SRC + 1)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [N_SRC-1:0]        irq_src_i,
  input  logic [N_SRC-1:0]        ie_i,
  input  logic [N_SRC*PRIO_W-1:0] prio_i,
  input  logic [PRIO_W-1:0]       threshold_i,
  input  logic                    claim_i,
  input  logic                    complete_i,
  input  logic [ID_W-1:0]         complete_id_i,
  output logic                    irq_o,
  output logic [ID_W-1:0]         claim_id_o,
  output logic                    claim_valid_o,
  output logic [N_SRC-1:0]        pending_o,
  output logic [N_SRC-1:0]        active_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_ACTIVE  = 2'd2
  } src_state_e;

  src_state_e          state_q [N_SRC];
  logic [ID_W-1:0]     best_id_q;
  logic [PRIO_W-1:0]   best_prio_q;

  logic [N_SRC-1:0]    claim_hit_c;
  logic [N_SRC-1:0]    cmpl_hit_c;
  logic [N_SRC-1:0]    cand_c;
  logic                claim_go_c;
  logic [ID_W-1:0]     win_id_c;
  logic [PRIO_W-1:0]   win_prio_c;
  logic                win_valid_c;

  // Claim targets the registered winner only if it is still pending and enabled;
  // complete only matches an ACTIVE source, so ID 0 and out-of-range IDs fall through.
  always_comb begin
    claim_hit_c = '0;
    cmpl_hit_c  = '0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      if ((best_id_q == ID_W'(k + 1)) && (state_q[k] == S_PENDING) && ie_i[k]) begin
        claim_hit_c[k] = claim_i && (best_prio_q > threshold_i);
      end
      if ((complete_id_i == ID_W'(k + 1)) && (state_q[k] == S_ACTIVE)) begin
        cmpl_hit_c[k] = complete_i;
      end
    end
    claim_go_c = |claim_hit_c;
  end

  // Highest priority wins; strict compare keeps the lowest ID on ties.
  always_comb begin
    cand_c      = '0;
    win_id_c    = '0;
    win_prio_c  = '0;
    win_valid_c = 1'b0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      cand_c[k] = (state_q[k] == S_PENDING) && ie_i[k] &&
                  (prio_i[k*PRIO_W +: PRIO_W] != '0) && !claim_hit_c[k];
      if (cand_c[k] && (prio_i[k*PRIO_W +: PRIO_W] > win_prio_c)) begin
        win_id_c    = ID_W'(k + 1);
        win_prio_c  = prio_i[k*PRIO_W +: PRIO_W];
        win_valid_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < int'(N_SRC); k++) begin
        state_q[k] <= S_IDLE;
      end
      best_id_q     <= '0;
      best_prio_q   <= '0;
      irq_o         <= 1'b0;
      claim_id_o    <= '0;
      claim_valid_o <= 1'b0;
    end else begin
      for (int k = 0; k < int'(N_SRC); k++) begin
        case (state_q[k])
          S_IDLE:    if (irq_src_i[k])   state_q[k] <= S_PENDING;
          S_PENDING: if (claim_hit_c[k]) state_q[k] <= S_ACTIVE;
          S_ACTIVE:  if (cmpl_hit_c[k])  state_q[k] <= S_IDLE;
          default:                       state_q[k] <= S_IDLE;
        endcase
      end
      best_id_q     <= win_id_c;
      best_prio_q   <= win_prio_c;
      irq_o         <= win_valid_c && (win_prio_c > threshold_i);
      claim_valid_o <= claim_i;
      if (claim_i) begin
        claim_id_o <= claim_go_c ? best_id_q : '0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < int'(N_SRC); k++) begin
      pending_o[k] = (state_q[k] == S_PENDING);
      active_o[k]  = (state_q[k] == S_ACTIVE);
    end
  end

endmodule

// File: tb/tb_periph_int_gateway.sv
// Directed and randomized checks of periph_int_gateway against a cycle-level reference model.
module tb_periph_int_gateway;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  irq_src, ie;
  logic [23:0] prio;
  logic [2:0]  thr;
  logic        claim, complete;
  logic [3:0]  cid;
  logic        irq, claim_valid;
  logic [3:0]  claim_id;
  logic [7:0]  pending, active;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-source state 0=idle 1=pending 2=active
  int m_st [N];
  int m_best_id, m_best_prio, m_irq, m_cid, m_cv;

  periph_int_gateway dut (
    .clk_i(clk), .rstn_i(rstn), .irq_src_i(irq_src), .ie_i(ie), .prio_i(prio),
    .threshold_i(thr), .claim_i(claim), .complete_i(complete), .complete_id_i(cid),
    .irq_o(irq), .claim_id_o(claim_id), .claim_valid_o(claim_valid),
    .pending_o(pending), .active_o(active)
  );

  always #5 clk = ~clk;

  function automatic int gp(input int i);
    return int'((prio >> (i * 3)) & 24'h7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_st[i] = 0;
    m_best_id = 0; m_best_prio = 0; m_irq = 0; m_cid = 0; m_cv = 0;
  endtask

  task automatic chk_all(input string tag);
    logic [7:0] pv, av;
    for (int i = 0; i < N; i++) begin
      pv[i] = (m_st[i] == 1);
      av[i] = (m_st[i] == 2);
    end
    chk({tag, ".irq"}, 32'(irq), 32'(m_irq));
    chk({tag, ".claim_id"}, 32'(claim_id), 32'(m_cid));
    chk({tag, ".claim_valid"}, 32'(claim_valid), 32'(m_cv));
    chk({tag, ".pending"}, 32'(pending), 32'(pv));
    chk({tag, ".active"}, 32'(active), 32'(av));
  endtask

  // Advance one clock: predict from pre-edge inputs, then compare just after the edge
  task automatic step(input string tag);
    int claimed, best_sc, w_id, w_prio, sc, p;
    int nst [N];
    int t_thr, t_claim;
    t_thr = int'(thr);
    t_claim = int'(claim);
    claimed = 0;
    if (claim && m_best_id != 0) begin
      if (m_best_prio > t_thr && m_st[m_best_id-1] == 1 && ie[m_best_id-1]) claimed = m_best_id;
    end
    best_sc = -1; w_id = 0; w_prio = 0;
    for (int i = 0; i < N; i++) begin
      p = gp(i);
      if (m_st[i] == 1 && ie[i] && p != 0 && (i + 1) != claimed) begin
        sc = p * 16 + (15 - i);
        if (sc > best_sc) begin best_sc = sc; w_id = i + 1; w_prio = p; end
      end
    end
    for (int i = 0; i < N; i++) begin
      nst[i] = m_st[i];
      if (m_st[i] == 0 && irq_src[i]) nst[i] = 1;
      if (m_st[i] == 1 && claimed == i + 1) nst[i] = 2;
      if (m_st[i] == 2 && complete && int'(cid) == i + 1) nst[i] = 0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) m_st[i] = nst[i];
    m_irq = (w_id != 0 && w_prio > t_thr) ? 1 : 0;
    m_best_id = w_id; m_best_prio = w_prio;
    m_cv = t_claim;
    if (t_claim != 0) m_cid = claimed;
    chk_all(tag);
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    #1 model_reset();
    chk_all("reset");
    #1 rstn = 1'b1;
  endtask

  task automatic set_prio(input int src, input int v);
    prio[src*3 +: 3] = 3'(v);
  endtask

  initial begin
    rstn = 1'b0; irq_src = '0; ie = '0; prio = '0; thr = '0;
    claim = 1'b0; complete = 1'b0; cid = '0;
    model_reset();
    #1 chk_all("por");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Basic flow: ID 3, prio 5
    ie = 8'hFF; set_prio(2, 5); irq_src[2] = 1'b1;
    step("basic.pend");
    chk("basic.pending2", 32'(pending[2]), 32'd1);
    step("basic.irq");
    chk("basic.irq_up", 32'(irq), 32'd1);
    claim = 1'b1; step("basic.claim"); claim = 1'b0;
    chk("basic.claim_id", 32'(claim_id), 32'd3);
    chk("basic.active2", 32'(active[2]), 32'd1);
    chk("basic.irq_down", 32'(irq), 32'd0);
    complete = 1'b1; cid = 4'd3; step("basic.cmpl"); complete = 1'b0;
    step("basic.repend");
    step("basic.reirq");
    chk("basic.irq_back", 32'(irq), 32'd1);
    irq_src = '0;
    claim = 1'b1; step("basic.claim2"); claim = 1'b0;
    complete = 1'b1; step("basic.cmpl2"); complete = 1'b0;

    // Priority and tie-break: IDs 2 (3), 5 (6), 7 (6)
    prio = '0; set_prio(1, 3); set_prio(4, 6); set_prio(6, 6);
    irq_src = 8'b0101_0010; step("prio.raise");
    irq_src = '0; step("prio.arb");
    claim = 1'b1;
    step("prio.c1"); chk("prio.first", 32'(claim_id), 32'd5);
    step("prio.c2"); chk("prio.second", 32'(claim_id), 32'd7);
    step("prio.c3"); chk("prio.third", 32'(claim_id), 32'd2);
    step("prio.c4"); chk("prio.none", 32'(claim_id), 32'd0);
    claim = 1'b0; complete = 1'b1;
    cid = 4'd5; step("prio.k5");
    cid = 4'd7; step("prio.k7");
    cid = 4'd2; step("prio.k2");
    complete = 1'b0;

    // Threshold and priority 0
    prio = '0; set_prio(0, 4); set_prio(3, 0); thr = 3'd4;
    irq_src = 8'b0000_1001; step("thr.raise");
    irq_src = '0; step("thr.a"); step("thr.b");
    chk("thr.irq_low", 32'(irq), 32'd0);
    claim = 1'b1; step("thr.claim0"); claim = 1'b0;
    chk("thr.claim_zero", 32'(claim_id), 32'd0);
    chk("thr.claim_pulse", 32'(claim_valid), 32'd1);
    thr = 3'd3; step("thr.lower");
    chk("thr.irq_up", 32'(irq), 32'd1);
    claim = 1'b1; step("thr.claim1"); claim = 1'b0;
    chk("thr.claim_one", 32'(claim_id), 32'd1);
    complete = 1'b1; cid = 4'd1; step("thr.k1"); complete = 1'b0;

    // Disable while pending: ID 6
    thr = 3'd0; set_prio(5, 2);
    irq_src[5] = 1'b1; step("dis.raise");
    irq_src[5] = 1'b0; step("dis.arb");
    chk("dis.irq_up", 32'(irq), 32'd1);
    ie[5] = 1'b0; step("dis.off");
    chk("dis.irq_off", 32'(irq), 32'd0);
    chk("dis.still_pend", 32'(pending[5]), 32'd1);
    ie[5] = 1'b1; step("dis.on");
    chk("dis.irq_back", 32'(irq), 32'd1);

    // Illegal completes leave state untouched
    complete = 1'b1;
    cid = 4'd0; step("ill.id0");
    cid = 4'd9; step("ill.id9");
    cid = 4'd6; step("ill.pend");
    complete = 1'b0;
    chk("ill.pend6", 32'(pending[5]), 32'd1);
    chk("ill.noact", 32'(active), 32'd0);

    // Simultaneous claim of ID 2 and complete of ACTIVE ID 4
    irq_src = '0; do_reset();
    ie = 8'hFF; thr = 3'd0; prio = '0; set_prio(1, 5); set_prio(3, 4);
    irq_src = 8'b0000_1000; step("sim.r4"); step("sim.a4");
    claim = 1'b1; step("sim.c4"); claim = 1'b0;
    chk("sim.claim4", 32'(claim_id), 32'd4);
    irq_src = 8'b0000_0010; step("sim.r2"); step("sim.a2");
    claim = 1'b1; complete = 1'b1; cid = 4'd4; step("sim.both");
    claim = 1'b0; complete = 1'b0;
    chk("sim.active", 32'(active), 32'h02);
    chk("sim.claim2", 32'(claim_id), 32'd2);

    // Async reset between claim and complete; held source re-pends
    do_reset();
    chk("rst.active", 32'(active), 32'd0);
    chk("rst.claim_id", 32'(claim_id), 32'd0);
    step("rst.repend");
    chk("rst.pend2", 32'(pending[1]), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      irq_src = 8'($urandom) & 8'($urandom);
      ie = 8'($urandom) | 8'($urandom);
      if ($urandom_range(0, 15) == 0) prio = 24'($urandom);
      if ($urandom_range(0, 31) == 0) thr = 3'($urandom_range(0, 5));
      claim = ($urandom_range(0, 2) == 0);
      complete = ($urandom_range(0, 2) == 0);
      cid = 4'($urandom_range(0, 10));
      step("rand");
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/periph_int_gateway.md
# periph_int_gateway

Level-sensitive interrupt gateway and priority arbiter for the hbirdv2 peripheral subsystem. It receives `interrupt_o` lines from the peripheral interrupt blocks (UART, SPI, GPIO, …), latches each as pending, selects the highest-priority enabled request above a threshold, and drives one interrupt to the core. The core takes ownership through a claim/complete handshake that stops a still-asserted level source from re-triggering until it is serviced.

## Interface
- `N_SRC`, default 8: number of interrupt sources. Source k has ID k+1; ID 0 means "none".
- `PRIO_W`, default 3: priority width. Priority 0 means the source never interrupts.
- `ID_W`, default `$clog2(N_SRC+1)`: derived ID width. Not to be overridden.
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  asynchronous active-low reset.
- `irq_src_i`  in  N_SRC  level interrupt from each peripheral; active high.
- `ie_i`  in  N_SRC  per-source enable.
- `prio_i`  in  N_SRC*PRIO_W  per-source priority; source k occupies `[k*PRIO_W +: PRIO_W]`.
- `threshold_i`  in  PRIO_W  a source can interrupt only when its priority is strictly greater than this value.
- `claim_i`  in  1  single-cycle claim strobe.
- `complete_i`  in  1  single-cycle complete strobe.
- `complete_id_i`  in  ID_W  ID being completed.
- `irq_o`  out  1  interrupt request to the core; registered.
- `claim_id_o`  out  ID_W  claimed ID; registered and held until the next claim.
- `claim_valid_o`  out  1  one-cycle pulse, one cycle after `claim_i`.
- `pending_o`  out  N_SRC  per-source PENDING state.
- `active_o`  out  N_SRC  per-source ACTIVE (claimed, not completed) state.

## Operation
- **Per-source FSM**, one state per source: IDLE, PENDING, ACTIVE.
  - IDLE → PENDING when `irq_src_i[k]` is 1.
  - PENDING → ACTIVE when source k is claimed.
  - ACTIVE → IDLE on `complete_i` with `complete_id_i == k+1`.
  - PENDING ignores `ie_i`. A disabled source keeps its pending state but is not arbitrated.
  - `irq_src_i` is ignored in PENDING and ACTIVE. A source still high after completion re-pends on the following cycle.
- **Arbitration (combinational)**
  - Candidates: PENDING & `ie_i` & priority ≠ 0, excluding any source being claimed this cycle.
  - Winner: highest priority; ties go to the lowest ID.
  - Result is registered into `best_id_q`/`best_prio_q`; both are 0 when there is no candidate.
- **irq_o**: registered as (comb winner exists) && (winner priority > `threshold_i`).
- **Claim**: on `claim_i`, if `best_id_q` ≠ 0, `best_prio_q` > `threshold_i`, and that source is still PENDING & enabled:
  - `claim_id_o` ← `best_id_q`;
  - that source → ACTIVE.
  - Otherwise `claim_id_o` ← 0.
  - In all cases `claim_valid_o` pulses on the next cycle.
- **Complete**: ignored if the ID is 0, greater than `N_SRC`, or the source is not ACTIVE. No error is flagged.
- **Simultaneous claim and complete**: both are applied in the same cycle. Completing ID X while claiming ID Y is legal, including X == Y's previous ownership.
- **Back-to-back claims**: because the claimed source is excluded from arbitration in the claim cycle, consecutive claims return distinct IDs in priority order.

## Timing
- **Reset**: all sources IDLE; `irq_o`=0, `claim_id_o`=0, `claim_valid_o`=0, `pending_o`=0, `active_o`=0, `best_id_q`=0.
- **Source rise at edge n**:
  - PENDING at n+1;
  - `irq_o` high at n+2;
  - earliest claim accepted with `claim_i` high during the cycle after n+2.
- **Claim latency**: `claim_id_o`, `claim_valid_o` and the ACTIVE transition all update on the edge that samples `claim_i`.
- **irq_o after claiming the only request**: deasserts on that same edge, because the comb winner excluded the source.
- **Threshold or enable changes**: take effect on `irq_o` one edge later.
- **Reset asserted mid-handshake**: aborts everything immediately. No claim or complete is retained.

## Test plan
- **Basic flow.** Reset, N_SRC=8; src 2 (ID 3), prio 5, ie=1, threshold 0. Raise `irq_src_i[2]`.
  - `irq_o`=1 two cycles later; claim → `claim_id_o`=3, `claim_valid_o` pulse, `active_o[2]`=1, `irq_o`=0.
  - Complete ID 3 with source still high → ACTIVE→IDLE→PENDING, `irq_o` returns.
- **Priority and tie-break.** IDs 2 (prio 3), 5 (prio 6), 7 (prio 6) pending.
  - Three back-to-back claims return 5, 7, 2.
  - A fourth claim returns 0.
- **Threshold and priority 0.** Threshold=4, ID 1 prio 4, ID 4 prio 0.
  - `irq_o` stays 0 and a claim returns 0 with a `claim_valid_o` pulse.
  - Lower threshold to 3 → `irq_o`=1 one edge later; claim returns 1.
- **Disable while pending.** ID 6 pending; drop `ie_i[5]`.
  - `irq_o`→0, `pending_o[5]` stays 1.
  - Re-enable → `irq_o`=1 one edge later.
- **Illegal and simultaneous completes.**
  - Complete ID 0, ID 9, and a PENDING ID → no state change.
  - Same-cycle claim of ID 2 and complete of ACTIVE ID 4 → ID 2 ACTIVE, ID 4 IDLE.
- **Async reset.** Assert `rstn_i` low between claim and complete → all outputs 0 immediately; after release a high source re-pends.
